serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, using a single full-adder cell and a carry flip-flop.
- Intended as the area-cheap arithmetic building block for the COA datapath, where several adders share a slow clock domain.
- Start/busy/done handshake; the registered result is held stable until the next operation completes.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- cin  input  1  carry-in; sampled only on an accepted start.
- sum  output  WIDTH  registered result, (a+b+cin) modulo 2^WIDTH.
- carry  output  1  registered carry-out of the MSB.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse; high in the cycle the new sum/carry first become valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on rst_n.
  - rst_n low forces immediately, without waiting for a clock edge: sum=0, carry=0, busy=0, done=0, state=IDLE, bit counter=0, and all internal shift and carry registers cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b, cin into internal shift registers; clear counter; go to RUN; busy=1 from that edge.
  - start=0: remain in IDLE.
- RUN, each edge:
  - s_bit = a_sh[0] ^ b_sh[0] ^ c.
  - c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])).
  - a_sh and b_sh shift right by one; s_bit enters the MSB of the partial-sum register, which shifts right.
  - Counter increments.
  - At the edge that processes bit WIDTH-1: copy the partial sum to sum, copy the final carry to carry, busy <= 0, done <= 1, go to DONE.
- DONE (lasts exactly one cycle):
  - done returns to 0 at the next edge.
  - start=1 at that edge is accepted exactly as in IDLE: new operands latched, go to RUN, busy=1.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k; done high for the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1 is ignored; the operands are not resampled and the result is unaffected.
- a, b, cin may change freely after the accepting edge.
- sum and carry hold the previous result during RUN. They change only at the completion edge or on reset.
- WIDTH=1: RUN lasts one edge; the block behaves as a registered full adder with 2-cycle start-to-done.
- The counter is sized to clog2(WIDTH)+1 bits. There is no wrap-around within an operation.

Test Plan:
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulse -> busy high for 8 cycles; done pulses once, 8 edges after the accepting edge; sum=0x96, carry=0.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carry=1.
- Ignored start: start with a=0x10, b=0x20; re-pulse start with a=0xAA, b=0x55 at cycle 3 of RUN -> result is sum=0x30, carry=0; exactly one done pulse.
- Back-to-back: start held high continuously, first op a=0x01, b=0x02, then a=0x80, b=0x80 presented during the DONE cycle -> first done with sum=0x03; second done 9 cycles later with sum=0x00, carry=1. sum stays 0x03 throughout the second RUN.
- Reset mid-op: rst_n low (asynchronously, between edges) at cycle 4 of RUN -> all outputs 0 immediately; no done pulse; after release, a fresh start a=0x0F, b=0x01 yields sum=0x10.
- Parameter sweep: WIDTH=1 (a=1, b=1, cin=1 -> sum=1, carry=1, done 1 edge after accept) and WIDTH=32 (a=0xFFFFFFFF, b=1 -> sum=0, carry=1, latency 32 edges), plus 1000 random vectors per WIDTH checked against a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop process one operand bit per clock.
// A start/busy/done handshake surrounds the addition; sum and carry hold until the next result completes.
`timescale 1ns/1ps

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] ps;
    logic             c;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic [WIDTH-1:0] ps_nx;
    logic             s_bit;
    logic             c_nx;
    logic             last;

    // Partial sum fills from the MSB; written as shift-then-patch so WIDTH=1 needs no special slice.
    always_comb begin
        s_bit = a_sh[0] ^ b_sh[0] ^ c;
        c_nx  = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
        a_nx  = a_sh >> 1;
        b_nx  = b_sh >> 1;
        ps_nx = ps >> 1;
        ps_nx[WIDTH-1] = s_bit;
        last  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            ps    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        ps    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_nx;
                    b_sh <= b_nx;
                    c    <= c_nx;
                    ps   <= ps_nx;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        sum   <= ps_nx;
                        carry <= c_nx;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 1, 8 and 32: vector table, handshake corner sequences, random sweep.
`timescale 1ns/1ps

module tb_serial_adder;

    typedef struct {
        logic [31:0] s;
        logic        c;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       c;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start1 = 1'b0, start8 = 1'b0, start32 = 1'b0;
    logic [31:0] a_v = '0, b_v = '0;
    logic        cin_v = 1'b0;

    logic [0:0]  sum1;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic        carry1, carry8, carry32;
    logic        busy1, busy8, busy32;
    logic        done1, done8, done32;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a_v[0:0]), .b(b_v[0:0]), .cin(cin_v),
        .sum(sum1), .carry(carry1), .busy(busy1), .done(done1)
    );
    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin_v),
        .sum(sum8), .carry(carry8), .busy(busy8), .done(done8)
    );
    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a_v), .b(b_v), .cin(cin_v),
        .sum(sum32), .carry(carry32), .busy(busy32), .done(done32)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] g_sum(input int w);
        case (w)
            1:       return {31'b0, sum1};
            8:       return {24'b0, sum8};
            default: return sum32;
        endcase
    endfunction

    function automatic logic g_carry(input int w);
        case (w)
            1:       return carry1;
            8:       return carry8;
            default: return carry32;
        endcase
    endfunction

    function automatic logic g_busy(input int w);
        case (w)
            1:       return busy1;
            8:       return busy8;
            default: return busy32;
        endcase
    endfunction

    function automatic logic g_done(input int w);
        case (w)
            1:       return done1;
            8:       return done8;
            default: return done32;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       start1 = v;
            8:       start8 = v;
            default: start32 = v;
        endcase
    endtask

    // One complete operation on the width-w instance; entered and left #1 after a rising edge.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic [31:0] es, input logic ec, input string tag);
        logic [31:0] prev_s;
        logic        prev_c;
        logic        hold_ok, busy_ok;
        int          n;
        exp_t        e;
        sb.push_back('{es, ec});
        a_v = a; b_v = b; cin_v = ci;
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        a_v = $urandom; b_v = $urandom; cin_v = 1'($urandom_range(0, 1));
        prev_s = g_sum(w); prev_c = g_carry(w);
        hold_ok = 1'b1; busy_ok = 1'b1; n = 0;
        while (g_done(w) !== 1'b1 && n < w + 10) begin
            if (g_busy(w) !== 1'b1) busy_ok = 1'b0;
            if (g_sum(w) !== prev_s || g_carry(w) !== prev_c) hold_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, n, w);
        chk({tag, " busy during run"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, " result held during run"}, {31'b0, hold_ok}, 32'd1);
        if (g_done(w) === 1'b1) begin
            chk({tag, " sum"}, g_sum(w), e.s);
            chk({tag, " carry"}, {31'b0, g_carry(w)}, {31'b0, e.c});
            chk({tag, " busy at done"}, {31'b0, g_busy(w)}, 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, {31'b0, g_done(w)}, 32'd0);
    endtask

    task automatic rand_op(input int w, input int idx);
        logic [31:0] m, a, b;
        logic [32:0] t;
        logic        ci;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a  = $urandom & m;
        b  = $urandom & m;
        ci = 1'($urandom_range(0, 1));
        t  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        do_op(w, a, b, ci, t[31:0] & m, t[w], $sformatf("rand w%0d #%0d", w, idx));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   n, dones;
        logic hold_ok, seen;
        exp_t e;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        tbl[7] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0};

        #1 rst_n = 1'b0;
        #2;
        chk("reset sum8",   {24'b0, sum8}, 32'd0);
        chk("reset carry8", {31'b0, carry8}, 32'd0);
        chk("reset busy8",  {31'b0, busy8}, 32'd0);
        chk("reset done8",  {31'b0, done8}, 32'd0);
        chk("reset sum1",   {31'b0, sum1}, 32'd0);
        chk("reset flags1", {29'b0, carry1, busy1, done1}, 32'd0);
        chk("reset sum32",  sum32, 32'd0);
        chk("reset flags32", {29'b0, carry32, busy32, done32}, 32'd0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            do_op(8, {24'b0, tbl[i].a}, {24'b0, tbl[i].b}, tbl[i].ci,
                  {24'b0, tbl[i].s}, tbl[i].c, $sformatf("vec%0d", i));

        // start re-pulsed during RUN must be ignored
        a_v = 32'h10; b_v = 32'h20; cin_v = 1'b0; start8 = 1'b1;
        sb.push_back('{32'h30, 1'b0});
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_v = 32'hAA; b_v = 32'h55; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        dones = 0;
        e = sb.pop_front();
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) begin
                dones++;
                chk("ignored start sum", {24'b0, sum8}, e.s);
                chk("ignored start carry", {31'b0, carry8}, {31'b0, e.c});
            end
            @(posedge clk); #1;
        end
        chk("ignored start done count", dones, 32'd1);

        // asynchronous reset in cycle 4 of RUN
        a_v = 32'h55; b_v = 32'h0A; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("async reset sum",   {24'b0, sum8}, 32'd0);
        chk("async reset carry", {31'b0, carry8}, 32'd0);
        chk("async reset busy",  {31'b0, busy8}, 32'd0);
        chk("async reset done",  {31'b0, done8}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
        end
        chk("aborted op stays silent", {31'b0, seen}, 32'd0);
        do_op(8, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, "post-reset");

        // back-to-back with start held high
        a_v = 32'h01; b_v = 32'h02; cin_v = 1'b0; start8 = 1'b1;
        sb.push_back('{32'h03, 1'b0});
        @(posedge clk); #1;
        a_v = 32'h33; b_v = 32'h44;
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("b2b first latency", n, 32'd8);
        e = sb.pop_front();
        chk("b2b first sum", {24'b0, sum8}, e.s);
        chk("b2b first carry", {31'b0, carry8}, {31'b0, e.c});
        a_v = 32'h80; b_v = 32'h80;
        sb.push_back('{32'h00, 1'b1});
        @(posedge clk); #1;
        chk("b2b reaccept busy", {31'b0, busy8}, 32'd1);
        chk("b2b reaccept done low", {31'b0, done8}, 32'd0);
        start8 = 1'b0;
        n = 1; hold_ok = 1'b1;
        while (done8 !== 1'b1 && n < 20) begin
            if (sum8 !== 8'h03) hold_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("b2b done spacing", n, 32'd9);
        chk("b2b sum held", {31'b0, hold_ok}, 32'd1);
        e = sb.pop_front();
        chk("b2b second sum", {24'b0, sum8}, e.s);
        chk("b2b second carry", {31'b0, carry8}, {31'b0, e.c});
        @(posedge clk); #1;

        do_op(1, 32'd1, 32'd1, 1'b1, 32'd1, 1'b1, "w1 full adder");
        do_op(32, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, "w32 carry chain");

        for (int i = 0; i < 1000; i++) rand_op(1, i);
        for (int i = 0; i < 1000; i++) rand_op(8, i);
        for (int i = 0; i < 1000; i++) rand_op(32, i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
